scan_addr_gen: RTL



---
 rtl/scan_addr_gen_pkg.sv | 29 ++
 rtl/scan_addr_gen_step.sv | 80 ++++++++
 rtl/scan_addr_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/scan_addr_gen_pkg.sv
// Shared types for the coefficient-scan address generator.
//   scan_mode_t : scan order latched at the start of a run
//   state_t     : controller state
//   decode_mode : maps the raw 2-bit mode input onto scan_mode_t (3 -> raster)
package scan_pkg;

  typedef enum logic [1:0] {
    SCAN_ZIGZAG = 2'd0,
    SCAN_RASTER = 2'd1,
    SCAN_COLUMN = 2'd2
  } scan_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic scan_mode_t decode_mode(input logic [1:0] raw);
    scan_mode_t m;
    unique case (raw)
      2'd0:    m = SCAN_ZIGZAG;
      2'd2:    m = SCAN_COLUMN;
      default: m = SCAN_RASTER;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/scan_addr_gen_step.sv
// scan_step: combinational next-coordinate logic for one scan step.
// Ports:
//   mode   : scan order
//   x, y   : current coordinate
//   nx, ny : coordinate following (x,y) in the chosen order
// At the final coordinate of a block the result is don't-care; callers
// restart at (0,0) themselves.
module scan_step
  import scan_pkg::*;
#(
  parameter int unsigned COL = 8,
  parameter int unsigned ROW = 8
) (
  input  scan_mode_t              mode,
  input  logic [$clog2(COL)-1:0]  x,
  input  logic [$clog2(ROW)-1:0]  y,
  output logic [$clog2(COL)-1:0]  nx,
  output logic [$clog2(ROW)-1:0]  ny
);

  localparam int unsigned XW = $clog2(COL);
  localparam int unsigned YW = $clog2(ROW);
  localparam logic [XW-1:0] XMAX = XW'(COL - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROW - 1);

  logic x_end;
  logic y_end;
  logic par;

  assign x_end = (x == XMAX);
  assign y_end = (y == YMAX);
  assign par   = x[0] ^ y[0];

  always_comb begin
    nx = x;
    ny = y;
    case (mode)
      SCAN_ZIGZAG: begin
        // Even anti-diagonal parity walks up-right, odd walks down-left;
        // edge checks order matters so corners turn correctly on non-square blocks.
        if (!par) begin
          if (x_end) begin
            ny = y + 1'b1;
          end else if (y == '0) begin
            nx = x + 1'b1;
          end else begin
            nx = x + 1'b1;
            ny = y - 1'b1;
          end
        end else begin
          if (y_end) begin
            nx = x + 1'b1;
          end else if (x == '0) begin
            ny = y + 1'b1;
          end else begin
            nx = x - 1'b1;
            ny = y + 1'b1;
          end
        end
      end
      SCAN_COLUMN: begin
        if (y_end) begin
          ny = '0;
          nx = x_end ? '0 : x + 1'b1;
        end else begin
          ny = y + 1'b1;
        end
      end
      default: begin
        if (x_end) begin
          nx = '0;
          ny = y_end ? '0 : y + 1'b1;
        end else begin
          nx = x + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/scan_addr_gen.sv
// scan_addr_gen: walks COL x ROW coefficient blocks in zigzag, raster or
// column-major order, repeating for num_blocks blocks per run.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a run (sampled only in IDLE)
//   mode, num_blocks  : scan order and block count, latched on start (0 -> 1)
//   ready             : downstream accepts the presented coordinate
//   abort             : (SCAN_ABORT_EN only) drop the run and return to IDLE
//   busy, valid       : run in progress / coordinate presented
//   x, y, idx         : coordinate and linear index y*COL+x
//   last_in_block     : final coordinate of the current block
//   last              : final coordinate of the run
//   done              : one-cycle pulse after the final handshake
// Build option: define SCAN_ABORT_EN to add the abort input.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int unsigned COL        = 8,
  parameter int unsigned ROW        = 8,
  parameter int unsigned MAX_BLOCKS = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [$clog2(MAX_BLOCKS+1)-1:0]   num_blocks,
  input  logic                              ready,
`ifdef SCAN_ABORT_EN
  input  logic                              abort,
`endif
  output logic                              busy,
  output logic                              valid,
  output logic [$clog2(COL)-1:0]            x,
  output logic [$clog2(ROW)-1:0]            y,
  output logic [$clog2(COL*ROW)-1:0]        idx,
  output logic                              last_in_block,
  output logic                              last,
  output logic                              done
);

  localparam int unsigned XW = $clog2(COL);
  localparam int unsigned YW = $clog2(ROW);
  localparam int unsigned IW = $clog2(COL * ROW);
  localparam int unsigned NW = $clog2(MAX_BLOCKS + 1);

  state_t          state_q;
  scan_mode_t      mode_q;
  logic [NW-1:0]   nblk_q;
  logic [NW-1:0]   blk_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [IW-1:0]   idx_q;

  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y_nxt;
  logic [IW-1:0]   idx_nxt;
  logic            blk_end;
  logic            run_end;

  scan_step #(
    .COL (COL),
    .ROW (ROW)
  ) u_step (
    .mode (mode_q),
    .x    (x_q),
    .y    (y_q),
    .nx   (x_nxt),
    .ny   (y_nxt)
  );

  // idx is kept as its own register so readers never see a multiplier path.
  assign idx_nxt = IW'(y_nxt) * IW'(COL) + IW'(x_nxt);

  assign blk_end = (state_q == SCAN) && (x_q == XW'(COL - 1)) && (y_q == YW'(ROW - 1));
  assign run_end = blk_end && (blk_q == nblk_q - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= SCAN_ZIGZAG;
      nblk_q  <= NW'(1);
      blk_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN;
            mode_q  <= decode_mode(mode);
            nblk_q  <= (num_blocks == '0) ? NW'(1) : num_blocks;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
          end
        end
        SCAN: begin
`ifdef SCAN_ABORT_EN
          if (abort) begin
            state_q <= IDLE;
            blk_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
          end else
`endif
          if (ready) begin
            if (blk_end) begin
              x_q   <= '0;
              y_q   <= '0;
              idx_q <= '0;
              if (run_end) begin
                state_q <= DONE;
                blk_q   <= '0;
              end else begin
                blk_q <= blk_q + 1'b1;
              end
            end else begin
              x_q   <= x_nxt;
              y_q   <= y_nxt;
              idx_q <= idx_nxt;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign valid         = (state_q == SCAN);
  assign done          = (state_q == DONE);
  assign x             = x_q;
  assign y             = y_q;
  assign idx           = idx_q;
  assign last_in_block = blk_end;
  assign last          = run_end;

endmodule
